msg_scroller: RTL and testbench
===============================

// Module: msg_scroller
// PURPOSE
//  Parametrised scrolling-message engine for the multi-digit 7-segment display.
//  It holds N_MSGS fixed messages of MSG_LEN characters as active-low segment codes.
//  It shows an N_DIGITS-wide window of the selected message and moves the window
//  on a prescaled tick, forward or backward. It also supports stop and single-step.
//  Sits between the board switches/buttons and the digit multiplexer.
// PARAMETERS
//  N_DIGITS  4           digits in the visible window
//  MSG_LEN   16          characters per message (power of 2; offset wraps mod MSG_LEN)
//  N_MSGS    2           number of stored messages
//  SEG_W     8           segment bits per character (dp + g..a, active-low)
//  TICK_DIV  25_000_000  clk cycles per scroll step (>=2)
// PORTS
//  clk      in   1                   system clock
//  rst      in   1                   synchronous, active-high reset
//  msg_sel  in   clog2(N_MSGS)       message select (max(1,...) bits)
//  run      in   1                   1 = auto-scroll, 0 = stopped
//  dir      in   1                   0 = window moves forward (+1), 1 = backward (-1)
//  step     in   1                   single-cycle pulse, advance one position when stopped
//  seg_out  out  N_DIGITS*SEG_W      digit k (0 = leftmost) at [(N_DIGITS-1-k)*SEG_W +: SEG_W]
//  pos      out  clog2(MSG_LEN)      current window offset
//  wrap     out  1                   1-cycle pulse when pos wraps (MSG_LEN-1->0 fwd, 0->MSG_LEN-1 bwd)
// BEHAVIOUR
//  Clock and reset: one clock (clk). Reset rst is synchronous and active-high.
//  Reset values:
//   - seg_out = all 1s (blank)
//   - pos = 0, wrap = 0
//   - prescaler = 0, state = S_STOP
//   - sel_q = msg_sel sampled at reset
//  Prescaler:
//   - In S_RUN, counts 0..TICK_DIV-1; tick = (cnt==TICK_DIV-1), then cnt returns to 0.
//   - Held at 0 outside S_RUN.
//  FSM:
//   - S_STOP: run=1 -> S_RUN. step=1 -> pos moves one in dir.
//   - S_RUN: run=0 -> S_STOP (pending tick discarded). tick -> pos moves one in dir.
//     step is ignored in S_RUN.
//   - S_LOAD: entered from any state when msg_sel != sel_q. Sets sel_q<=msg_sel,
//     pos<=0, cnt<=0. Next cycle returns to S_RUN if run=1, otherwise S_STOP.
//  Priority: rst > msg_sel change (S_LOAD) > run/stop transition > tick/step.
//   A tick coinciding with a msg_sel change is dropped.
//  Arithmetic: pos is updated mod MSG_LEN by natural wrap of the clog2 width.
//   wrap is asserted in the same cycle that pos takes its wrapped value.
//  Output:
//   - digit k = ROM[sel_q][(pos+k) mod MSG_LEN].
//   - seg_out is registered: it reflects pos/sel_q one cycle after they change.
//   - seg_out is blank (all 1s) while in S_LOAD.
//  ROM contents (N_MSGS=2, MSG_LEN=16):
//   - msg 0 = "HELLO   HELLO   ": H=89 E=86 L=C7 O=C0 SP=FF.
//   - msg 1 = "GOOdbyE GOOdbyE ": G=C2 O=C0 d=A1 b=83 y=91 E=86 SP=FF.
//   - Indexes outside the defined messages read FF.
//  Reset mid-operation: returns to the reset values on the next edge. No partial step is kept.
// STRUCTURE
//  Shared constants include (msg_pkg.vh):
//   - SEG_* character codes, SEG_BLANK=8'hFF
//   - state encodings S_STOP/S_RUN/S_LOAD
//  Sub-module msg_char_rom (msg, adr -> seg), combinational.
//   Instantiated N_DIGITS times in a generate loop. Outputs are registered in msg_scroller.
// TESTING (N_DIGITS=4, MSG_LEN=16, TICK_DIV=4)
//  1. rst=1 for 2 cycles, msg_sel=0, run=0
//     -> seg_out=FFFF_FFFF, pos=0, wrap=0.
//     One cycle after release: seg_out=8986_C7C7.
//  2. run=1, dir=0
//     -> pos increments every 4 cycles. After first tick: seg_out=86C7_C7C0.
//     After 5 ticks: FFFF_FF89.
//  3. run=1, dir=0 for 16 ticks
//     -> pos 15->0, wrap high exactly 1 cycle, seg_out=8986_C7C7.
//  4. From pos=0: dir=1, one tick
//     -> pos=15, wrap=1 for 1 cycle, seg_out=FF89_86C7.
//  5. While running, msg_sel 0->1 in the same cycle as a tick
//     -> tick dropped, pos=0, one blank cycle, then seg_out=C2C0_C0A1.
//     Next tick 4 cycles after S_LOAD exit.
//  6. run=0, step pulse -> pos+1. step while run=1 -> no extra move.
//     rst asserted mid-scroll -> blank, pos=0.

Source files
------------

// File: rtl/msg_scroller_pkg.sv
// Shared constants for the scrolling-message engine.
//  - SEG_* : active-low character codes (dp + g..a), SEG_BLANK = all segments off
//  - state_t : controller states
//  - idx_width() : index width helper, never below 1 bit
//  - rom_code() : fixed message table lookup (2 messages x 16 characters)
package msg_scroller_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_H     = 8'h89;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_L     = 8'hC7;
  localparam logic [7:0] SEG_O     = 8'hC0;
  localparam logic [7:0] SEG_G     = 8'hC2;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_Y     = 8'h91;

  localparam int ROM_MSGS = 2;
  localparam int ROM_LEN  = 16;

  // Element 0 is the first character of the message.
  localparam logic [0:15][7:0] MSG0 = {
    SEG_H, SEG_E, SEG_L, SEG_L, SEG_O, SEG_BLANK, SEG_BLANK, SEG_BLANK,
    SEG_H, SEG_E, SEG_L, SEG_L, SEG_O, SEG_BLANK, SEG_BLANK, SEG_BLANK
  };
  localparam logic [0:15][7:0] MSG1 = {
    SEG_G, SEG_O, SEG_O, SEG_D, SEG_B, SEG_Y, SEG_E, SEG_BLANK,
    SEG_G, SEG_O, SEG_O, SEG_D, SEG_B, SEG_Y, SEG_E, SEG_BLANK
  };

  typedef enum logic [1:0] {
    S_STOP,
    S_RUN,
    S_LOAD
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [7:0] rom_code(input logic m, input logic [3:0] a);
    return m ? MSG1[a] : MSG0[a];
  endfunction

endpackage

// File: rtl/msg_scroller_if.sv
// Control/display bundle between the switch/button front end and the scroller.
//  master : drives msg_sel, run, dir, step; observes seg_out, pos, wrap
//  slave  : the scroller side
// Parameters must match the ones given to msg_scroller.
interface msg_scroller_if #(
  parameter int N_DIGITS = 4,
  parameter int MSG_LEN  = 16,
  parameter int N_MSGS   = 2,
  parameter int SEG_W    = 8
);
  import msg_scroller_pkg::*;

  localparam int SEL_W = idx_width(N_MSGS);
  localparam int POS_W = idx_width(MSG_LEN);

  logic [SEL_W-1:0]          msg_sel;
  logic                      run;
  logic                      dir;
  logic                      step;
  logic [N_DIGITS*SEG_W-1:0] seg_out;
  logic [POS_W-1:0]          pos;
  logic                      wrap;

  modport master (
    output msg_sel, run, dir, step,
    input  seg_out, pos, wrap
  );

  modport slave (
    input  msg_sel, run, dir, step,
    output seg_out, pos, wrap
  );

endinterface

// File: rtl/msg_scroller_rom.sv
// msg_char_rom: combinational character lookup.
//  msg : message index
//  adr : character index within the message
//  seg : active-low segment code; anything outside the stored table reads blank
module msg_char_rom
  import msg_scroller_pkg::*;
#(
  parameter int SEL_W = 1,
  parameter int POS_W = 4,
  parameter int SEG_W = 8
) (
  input  logic [SEL_W-1:0] msg,
  input  logic [POS_W-1:0] adr,
  output logic [SEG_W-1:0] seg
);

  logic [7:0] code;

  always_comb begin
    code = SEG_BLANK;
    if (int'(msg) < ROM_MSGS && int'(adr) < ROM_LEN)
      code = rom_code(msg[0], 4'(adr));
  end

  // Bits beyond the 8 stored ones stay off (high).
  always_comb begin
    seg = '1;
    for (int unsigned b = 0; b < SEG_W && b < 8; b++)
      seg[b] = code[b];
  end

endmodule

// File: rtl/msg_scroller.sv
// msg_scroller: shows an N_DIGITS-wide window of a stored message on a
// 7-segment bank and scrolls it on a prescaled tick, forward or backward,
// with stop and single-step.
//  clk, rst     : clock, synchronous active-high reset
//  bus.msg_sel  : message select (change reloads the window at offset 0)
//  bus.run      : 1 = auto-scroll, 0 = stopped
//  bus.dir      : 0 = forward (+1), 1 = backward (-1)
//  bus.step     : one-cycle pulse, moves one position while stopped
//  bus.seg_out  : digit k (0 = leftmost) at [(N_DIGITS-1-k)*SEG_W +: SEG_W]
//  bus.pos      : current window offset
//  bus.wrap     : one-cycle pulse when pos wraps
module msg_scroller
  import msg_scroller_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int MSG_LEN  = 16,
  parameter int N_MSGS   = 2,
  parameter int SEG_W    = 8,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic          clk,
  input  logic          rst,
  msg_scroller_if.slave bus
);

  localparam int SEL_W = idx_width(N_MSGS);
  localparam int POS_W = idx_width(MSG_LEN);
  localparam int CNT_W = idx_width(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic [POS_W-1:0]          pos_q;
  logic                      wrap_q;
  logic [SEL_W-1:0]          sel_q;
  logic [N_DIGITS*SEG_W-1:0] seg_q;
  logic [N_DIGITS*SEG_W-1:0] rom_word;
  logic [POS_W-1:0]          pos_nxt;
  logic                      wrap_nxt;

  // One move in the current direction; wrap falls out of the natural width.
  always_comb begin
    pos_nxt  = bus.dir ? pos_q - POS_W'(1) : pos_q + POS_W'(1);
    wrap_nxt = bus.dir ? (pos_q == '0) : (pos_q == '1);
  end

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    logic [POS_W-1:0] adr;
    assign adr = pos_q + POS_W'(k);
    msg_char_rom #(
      .SEL_W (SEL_W),
      .POS_W (POS_W),
      .SEG_W (SEG_W)
    ) u_rom (
      .msg (sel_q),
      .adr (adr),
      .seg (rom_word[(N_DIGITS-1-k)*SEG_W +: SEG_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_STOP;
      cnt    <= '0;
      pos_q  <= '0;
      wrap_q <= 1'b0;
      sel_q  <= bus.msg_sel;
      seg_q  <= '1;
    end else begin
      wrap_q <= 1'b0;
      seg_q  <= (state == S_LOAD) ? '1 : rom_word;
      // A message change overrides everything, including a coincident tick.
      if (bus.msg_sel != sel_q) begin
        state <= S_LOAD;
        sel_q <= bus.msg_sel;
        pos_q <= '0;
        cnt   <= '0;
      end else begin
        case (state)
          S_LOAD: begin
            state <= bus.run ? S_RUN : S_STOP;
            cnt   <= '0;
          end
          S_STOP: begin
            cnt <= '0;
            if (bus.run) begin
              state <= S_RUN;
            end else if (bus.step) begin
              pos_q  <= pos_nxt;
              wrap_q <= wrap_nxt;
            end
          end
          S_RUN: begin
            if (!bus.run) begin
              state <= S_STOP;
              cnt   <= '0;
            end else if (cnt == CNT_MAX) begin
              cnt    <= '0;
              pos_q  <= pos_nxt;
              wrap_q <= wrap_nxt;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= S_STOP;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.seg_out = seg_q;
  assign bus.pos     = pos_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_msg_scroller.sv
// Testbench for msg_scroller (N_DIGITS=4, MSG_LEN=16, TICK_DIV=4).
// Stimulus pushes expected outputs tagged with the clock interval they belong
// to; a monitor pops and compares them on the falling edge.
module tb_msg_scroller;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  msg_scroller_if #(.N_DIGITS(4), .MSG_LEN(16), .N_MSGS(2), .SEG_W(8)) bus ();

  msg_scroller #(
    .N_DIGITS (4),
    .MSG_LEN  (16),
    .N_MSGS   (2),
    .SEG_W    (8),
    .TICK_DIV (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int          at;
    logic [31:0] seg;
    logic [3:0]  pos;
    logic        wrap;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic push(input int at, input logic [31:0] seg, input int pos,
                      input logic wrap, input string name);
    exp_t e;
    e.at   = at;
    e.seg  = seg;
    e.pos  = 4'(pos);
    e.wrap = wrap;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.at != cyc || bus.seg_out !== mon_e.seg ||
          bus.pos !== mon_e.pos || bus.wrap !== mon_e.wrap) begin
        errors++;
        $display("FAIL %s cyc=%0d (due %0d) got seg=%h pos=%0d wrap=%b expected seg=%h pos=%0d wrap=%b",
                 mon_e.name, cyc, mon_e.at, bus.seg_out, bus.pos, bus.wrap,
                 mon_e.seg, mon_e.pos, mon_e.wrap);
      end
    end
  end

  int c;

  initial begin
    rst = 1'b1;
    bus.msg_sel = 1'b0;
    bus.run = 1'b0;
    bus.dir = 1'b0;
    bus.step = 1'b0;

    // Reset, then release
    adv(2); c = cyc;
    push(c,     32'hFFFF_FFFF, 0, 1'b0, "reset");
    rst = 1'b0;
    push(c + 1, 32'h8986_C7C7, 0, 1'b0, "release");

    // Forward auto-scroll through a full forward wrap
    adv(1); c = cyc;
    bus.run = 1'b1;
    push(c + 4,  32'h8986_C7C7, 0,  1'b0, "pre_tick");
    push(c + 5,  32'h8986_C7C7, 1,  1'b0, "tick1_pos");
    push(c + 6,  32'h86C7_C7C0, 1,  1'b0, "tick1_seg");
    push(c + 22, 32'hFFFF_FF89, 5,  1'b0, "tick5");
    push(c + 64, 32'hFF89_86C7, 15, 1'b0, "pos15");
    push(c + 65, 32'hFF89_86C7, 0,  1'b1, "wrap_fwd");
    push(c + 66, 32'h8986_C7C7, 0,  1'b0, "wrap_fwd_end");

    // Backward wrap 0 -> 15
    adv(66); c = cyc;
    bus.dir = 1'b1;
    push(c + 2, 32'h8986_C7C7, 0,  1'b0, "bwd_pre");
    push(c + 3, 32'h8986_C7C7, 15, 1'b1, "wrap_bwd");
    push(c + 4, 32'hFF89_86C7, 15, 1'b0, "wrap_bwd_seg");

    // Message change coinciding with a tick
    adv(4); c = cyc;
    bus.dir = 1'b0;
    push(c + 2, 32'hFF89_86C7, 15, 1'b0, "pre_load");
    push(c + 3, 32'hFF89_86C7, 0,  1'b0, "load_drop_tick");
    push(c + 4, 32'hFFFF_FFFF, 0,  1'b0, "load_blank");
    push(c + 5, 32'hC2C0_C0A1, 0,  1'b0, "msg1_seg");
    push(c + 7, 32'hC2C0_C0A1, 0,  1'b0, "msg1_pre_tick");
    push(c + 8, 32'hC2C0_C0A1, 1,  1'b0, "msg1_tick");
    push(c + 9, 32'hC0C0_A183, 1,  1'b0, "msg1_tick_seg");
    adv(2);
    bus.msg_sel = 1'b1;
    adv(7); c = cyc;

    // Stop and single-step
    bus.run = 1'b0;
    push(c + 2, 32'hC0C0_A183, 1, 1'b0, "stopped");
    push(c + 3, 32'hC0C0_A183, 2, 1'b0, "step_move");
    push(c + 4, 32'hC0A1_8391, 2, 1'b0, "step_seg");
    push(c + 8, 32'hC0A1_8391, 2, 1'b0, "stop_hold");
    adv(2);
    bus.step = 1'b1;
    adv(1);
    bus.step = 1'b0;
    adv(5); c = cyc;

    // Step while run is (re)asserted has no effect
    bus.run = 1'b1;
    bus.step = 1'b1;
    push(c + 2, 32'hC0A1_8391, 2, 1'b0, "run_step_ignored");
    push(c + 4, 32'hC0A1_8391, 2, 1'b0, "run_pre_tick");
    push(c + 5, 32'hC0A1_8391, 3, 1'b0, "run_tick");
    push(c + 6, 32'hA183_9186, 3, 1'b0, "run_tick_seg");
    adv(2);
    bus.step = 1'b0;
    adv(4); c = cyc;

    // Reset mid-scroll
    rst = 1'b1;
    push(c + 1, 32'hFFFF_FFFF, 0, 1'b0, "mid_rst");
    adv(1); c = cyc;
    rst = 1'b0;
    push(c + 1, 32'hC2C0_C0A1, 0, 1'b0, "post_rst");
    push(c + 4, 32'hC2C0_C0A1, 0, 1'b0, "post_rst_pre_tick");
    push(c + 5, 32'hC2C0_C0A1, 1, 1'b0, "post_rst_tick");

    for (int i = 0; i < 40 && sb.size() > 0; i++) adv(1);
    if (sb.size() > 0) begin
      errors += sb.size();
      $display("FAIL scoreboard_drain left=%0d expected left=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
